// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered read port, occupancy flags and optional sticky error flags.
// Define SYNC_FIFO_ERR_EN to build the overflow/underflow detectors; otherwise both outputs tie to 0.
module sync_fifo_param #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8,
  parameter int AF_LVL = 240,
  parameter int AE_LVL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  // Flags come only from the count register, so no enable-to-flag combinational path.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage is never reset; rst/clr simply suppress the write.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters: vector table plus fill/drain, wrap and flush/reset sequences.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst, clr, wr_en, rd_en;
  logic [8:0] wr_data, rd_data, count;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_param #(.DATA_W(9), .ADDR_W(8), .AF_LVL(240), .AE_LVL(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, wr, rd;
    logic [8:0] wd;
    logic [8:0] cnt;
    logic       emp, ful, ae, rv, uf;
    logic [8:0] rdd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic r, input logic [8:0] d);
    clr = c; wr_en = w; rd_en = r; wr_data = d;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 1);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
    chk({tag, " rd_data"}, 32'(rd_data), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] exp_d;
    logic       exp_v;
    int         wcnt;

    rst = 1'b1;
    drive(0, 0, 0, '0);
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Short mixed traffic, including both simultaneous-request corner cases and a flush.
    tbl[0] = '{0, 1, 0, 9'h011, 1, 0, 0, 1, 0, 0,      9'h000};
    tbl[1] = '{0, 1, 0, 9'h022, 2, 0, 0, 1, 0, 0,      9'h000};
    tbl[2] = '{0, 1, 1, 9'h033, 2, 0, 0, 1, 1, 0,      9'h011};
    tbl[3] = '{0, 0, 1, 9'h000, 1, 0, 0, 1, 1, 0,      9'h022};
    tbl[4] = '{0, 0, 0, 9'h000, 1, 0, 0, 1, 0, 0,      9'h022};
    tbl[5] = '{0, 0, 1, 9'h000, 0, 1, 0, 1, 1, 0,      9'h033};
    tbl[6] = '{0, 0, 1, 9'h000, 0, 1, 0, 1, 0, ERR_EN, 9'h033};
    tbl[7] = '{0, 1, 1, 9'h155, 1, 0, 0, 1, 0, ERR_EN, 9'h033};
    tbl[8] = '{0, 0, 1, 9'h000, 0, 1, 0, 1, 1, ERR_EN, 9'h155};
    tbl[9] = '{1, 1, 0, 9'h0AB, 0, 1, 0, 1, 0, 0,      9'h155};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      tick();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].ful));
      chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].rdd));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tbl[i].uf));
    end

    // Fill 0x000..0x0FF.
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 9'(i));
      tick();
      chk("fill count", 32'(count), 32'(i + 1));
      chk("fill almost_full", 32'(almost_full), 32'(i + 1 >= 240));
      chk("fill almost_empty", 32'(almost_empty), 32'(i + 1 <= 16));
      chk("fill full", 32'(full), 32'(i == 255));
    end

    // Full with both requests: read wins, 0x1AA is dropped.
    drive(0, 1, 1, 9'h1AA);
    tick();
    chk("full rw count", 32'(count), 255);
    chk("full rw rd_valid", 32'(rd_valid), 1);
    chk("full rw rd_data", 32'(rd_data), 0);
    chk("full rw overflow", 32'(overflow), 32'(ERR_EN));

    for (int i = 1; i < 256; i++) begin
      drive(0, 0, 1, '0);
      tick();
      chk("drain rd_valid", 32'(rd_valid), 1);
      chk("drain rd_data", 32'(rd_data), 32'(i));
      chk("drain count", 32'(count), 32'(255 - i));
    end
    chk("drain empty", 32'(empty), 1);
    drive(0, 0, 0, '0);
    tick();
    chk("idle rd_valid", 32'(rd_valid), 0);
    chk("idle rd_data hold", 32'(rd_data), 9'h0FF);

    // 300 writes / 300 reads with both pointers wrapping; queue is the reference.
    wcnt = 0;
    for (int c = 0; c < 550; c++) begin
      logic w, r;
      w = (wcnt < 300);
      r = (c >= 250);
      drive(0, w, r, 9'(wcnt) ^ 9'h0A5);
      exp_v = 1'b0;
      exp_d = '0;
      if (r && q.size() > 0) begin
        exp_v = 1'b1;
        exp_d = q.pop_front();
      end
      if (w && q.size() < 256) begin
        q.push_back(9'(wcnt) ^ 9'h0A5);
        wcnt++;
      end
      tick();
      chk("wrap count", 32'(count), 32'(q.size()));
      chk("wrap almost_full", 32'(almost_full), 32'(q.size() >= 240));
      chk("wrap almost_empty", 32'(almost_empty), 32'(q.size() <= 16));
      chk("wrap rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) chk("wrap rd_data", 32'(rd_data), 32'(exp_d));
    end
    chk("wrap empty", 32'(empty), 1);

    // Flush with a same-cycle write, then reset mid-transfer.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 9'h100 + 9'(i));
      tick();
    end
    chk("pre-clr count", 32'(count), 10);
    drive(1, 1, 0, 9'h1FF);
    tick();
    chk("clr count", 32'(count), 0);
    chk("clr empty", 32'(empty), 1);
    chk("clr rd_valid", 32'(rd_valid), 0);
    chk("clr overflow", 32'(overflow), 0);
    chk("clr rd_data hold", 32'(rd_data), 32'(exp_d));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 9'h0C0 + 9'(i));
      tick();
    end
    chk("post-clr first word", 32'(count), 3);
    drive(0, 0, 1, '0);
    tick();
    chk("post-clr rd_data", 32'(rd_data), 9'h0C0);
    rst = 1'b1;
    drive(0, 1, 1, 9'h077);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, '0);
    chk_reset_state("midrst");
    drive(0, 0, 1, '0);
    tick();
    chk("midrst read rd_valid", 32'(rd_valid), 0);
    chk("midrst read count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 9, giving the data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 8, giving the address width; depth DEPTH = 2**ADDR_W (default 256).
REQ-003 The module SHALL have parameter AF_LVL, default 240, giving the almost-full threshold in words.
REQ-004 The module SHALL have parameter AE_LVL, default 16, giving the almost-empty threshold in words.
REQ-005 Port clk, input, 1 bit: clock; all state SHALL change on its rising edge only.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port clr, input, 1 bit: synchronous flush.
REQ-008 Port wr_en, input, 1 bit: write request.
REQ-009 Port wr_data, input, DATA_W bits: write word.
REQ-010 Port rd_en, input, 1 bit: read request.
REQ-011 Port rd_data, output, DATA_W bits: registered read word.
REQ-012 Port rd_valid, output, 1 bit: rd_data updated this cycle.
REQ-013 Port full / empty, output, 1 bit each: occupancy == DEPTH / occupancy == 0.
REQ-014 Port almost_full / almost_empty, output, 1 bit each: count >= AF_LVL / count <= AE_LVL.
REQ-015 Port count, output, ADDR_W+1 bits: words stored, range 0..DEPTH.
REQ-016 Port overflow / underflow, output, 1 bit each: sticky error flags (see Configuration).

Function
REQ-017 A write SHALL be accepted when wr_en=1 and full=0: wr_data stored at wr_ptr, wr_ptr incremented.
REQ-018 A read SHALL be accepted when rd_en=1 and empty=0: word at rd_ptr loaded into rd_data next edge, rd_ptr incremented, rd_valid=1 the following cycle (latency 1).
REQ-019 When no read is accepted, rd_valid SHALL be 0 and rd_data SHALL hold its previous value.
REQ-020 wr_ptr and rd_ptr SHALL be ADDR_W bits and wrap DEPTH-1 -> 0 without error.
REQ-021 count SHALL be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or on neither.
REQ-022 full, empty, almost_full, almost_empty SHALL be decoded from the count register only (no combinational path from wr_en/rd_en).
REQ-023 When full=1, wr_en=1, rd_en=1: read SHALL be accepted, write rejected, count becomes DEPTH-1.
REQ-024 When empty=1, wr_en=1, rd_en=1: write SHALL be accepted, read rejected, rd_valid=0, count becomes 1.
REQ-025 Rejected writes SHALL NOT modify memory, pointers or count; rejected reads SHALL NOT modify rd_data, pointers or count.
REQ-026 clr=1 SHALL set wr_ptr, rd_ptr, count to 0 and rd_valid to 0 next edge, with priority over same-cycle wr_en/rd_en; rd_data holds.

Reset
REQ-027 rst SHALL have priority over clr, wr_en, rd_en.
REQ-028 On rst: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-029 Memory contents SHALL NOT be reset; rst asserted mid-transfer SHALL discard all stored words.

Configuration
REQ-030 With macro SYNC_FIFO_ERR_EN defined, overflow SHALL set on wr_en=1 while full=1, underflow on rd_en=1 while empty=1; both hold until rst or clr.
REQ-031 Without SYNC_FIFO_ERR_EN, overflow and underflow SHALL be constant 0 and no error logic synthesised.

Verification (DATA_W=9, ADDR_W=8, AF_LVL=240, AE_LVL=16)
REQ-032 Write 0x000..0x0FF (256 words), then read 256 -> full=1 after 256th write, rd_data 0x000..0x0FF in order, rd_valid one cycle after each rd_en, empty=1 at end.
REQ-033 Fill to 256, hold wr_en=1 and rd_en=1 one cycle with wr_data=0x1AA -> count=255, 0x1AA not stored, overflow=1 only if SYNC_FIFO_ERR_EN.
REQ-034 From empty, wr_en=1 and rd_en=1 with wr_data=0x155 -> count=1, rd_valid=0; next read returns 0x155.
REQ-035 Write 300 / read 300 interleaved across pointer wrap -> data order preserved, almost_full=1 exactly at count>=240, almost_empty=1 exactly at count<=16.
REQ-036 Write 10 words, assert clr with wr_en=1 -> count=0, empty=1; then assert rst -> rd_data=0x000, all flags at reset values.
